// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction memory and
// holds one fetched word in an IF/ID register handed to decode via valid/ready.
module fetch_unit #(
   parameter int unsigned     AW       = 6,
   parameter logic [AW-1:0]   RESET_PC = '0,
   parameter int unsigned     CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fetch_en,
   output logic [AW-1:0]    imem_addr,
   input  logic [31:0]      imem_instr,
   input  logic             redirect_valid,
   input  logic [AW-1:0]    redirect_target,
   output logic             if_valid,
   output logic [31:0]      if_instr,
   output logic [AW-1:0]    if_pc,
   input  logic             id_ready,
   output logic [AW-1:0]    pc,
   output logic [CNT_W-1:0] fetch_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic EMPTY = 1'b0;
   localparam logic FULL  = 1'b1;

   logic          state;
   logic          load;
   logic          drain;
   logic          hold;
   logic [AW-1:0] pc_inc;

   assign if_valid  = (state == FULL);
   assign imem_addr = pc;
   assign pc_inc    = pc + AW'(1);

   // Redirect outranks everything below reset, so load/drain/hold are all masked by it.
   always_comb begin
      load  = 1'b0;
      drain = 1'b0;
      hold  = 1'b0;
      if (!redirect_valid) begin
         load  = fetch_en && (!if_valid || id_ready);
         drain = if_valid && id_ready && !fetch_en;
         hold  = if_valid && !id_ready;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= EMPTY;
         pc       <= RESET_PC;
         if_instr <= '0;
         if_pc    <= '0;
      end else if (redirect_valid) begin
         state <= EMPTY;
         pc    <= redirect_target;
      end else if (load) begin
         state    <= FULL;
         if_instr <= imem_instr;
         if_pc    <= pc;
         pc       <= pc_inc;
      end else if (drain) begin
         state <= EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (load && (fetch_cnt != '1))
            fetch_cnt <= fetch_cnt + CNT_W'(1);
         if (hold && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule
